pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder_if.sv | 28 ++
 rtl/pmem_responder.sv | 120 ++++++++++++
 tb/tb_pmem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pmem_responder_if
// Description : Line-granular physical-memory bus between a cache-side
//               initiator (master) and the memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, proto_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pmem_responder
// Description : Fixed-latency 128-bit line memory model. Accepts one read or
//               write at a time, answers with a one-cycle pmem_resp pulse
//               LATENCY edges after acceptance, flags read+write conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pmem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_is_read;
    logic [IDX_W-1:0]   r_index;
    logic [127:0]       r_line;
    logic [127:0]       r_rdata;
    logic               r_resp;
    logic               r_proto_err;
    logic [127:0]       r_mem [DEPTH_LINES];

    logic               w_accept;
    logic               w_commit;
    logic               w_unused_addr;

    // A request is only looked at while idle; everything else is ignored.
    assign w_accept = (r_state == IDLE) && (bus.pmem_read || bus.pmem_write);
    // Writes land in storage on the edge that moves BUSY into RESP.
    assign w_commit = (r_state == BUSY) && (r_count == CNT_W'(1)) && !r_is_read;

    // Byte-offset and alias bits above the index do not select storage.
    assign w_unused_addr = ^{bus.pmem_address[15:4+IDX_W], bus.pmem_address[3:0]};

    assign bus.pmem_rdata = r_rdata;
    assign bus.pmem_resp  = r_resp;
    assign bus.proto_err  = r_proto_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: IDLE -> BUSY on a request, BUSY -> RESP when the
    // countdown hits 1, RESP always falls back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = BUSY;
            BUSY:    if (r_count == CNT_W'(1)) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture, countdown, response pulse, read data and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_is_read   <= 1'b0;
            r_index     <= '0;
            r_line      <= '0;
            r_rdata     <= '0;
            r_resp      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_resp <= (r_state == RESP);
            if (w_accept) begin
                // A simultaneous read+write is served as a read; the write
                // data is dropped and the conflict is remembered.
                r_is_read <= bus.pmem_read;
                r_index   <= bus.pmem_address[4 +: IDX_W];
                r_line    <= bus.pmem_wdata;
                r_count   <= C_CNT_LOAD;
                if (bus.pmem_read && bus.pmem_write) begin
                    r_proto_err <= 1'b1;
                end
            end else if (r_state == BUSY) begin
                r_count <= r_count - CNT_W'(1);
            end
            if ((r_state == RESP) && r_is_read) begin
                r_rdata <= r_mem[r_index];
            end
        end
    end

    // Line storage, cleared by reset so an aborted write never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_index] <= r_line;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pmem_responder
// Description : Directed bench for pmem_responder at LATENCY 4, 2 and 15,
//               with a read-data scoreboard and a reference line store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_responder;

    logic clk;
    logic rst_n;

    pmem_responder_if bus4 ();
    pmem_responder_if bus2 ();
    pmem_responder_if bus15 ();

    pmem_responder #(.LATENCY(4), .DEPTH_LINES(16)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    pmem_responder #(.LATENCY(2), .DEPTH_LINES(16)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    pmem_responder #(.LATENCY(15), .DEPTH_LINES(16)) u_dut15 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks;
    int            errors;
    logic [127:0]  sb_q [$];
    logic [127:0]  model [3][16];
    logic [127:0]  last_rd [3];
    logic          exp_err [3];

    localparam logic [127:0] C_LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] C_LINE_AA = {16{8'hAA}};
    localparam logic [127:0] C_LINE_55 = {16{8'h55}};
    localparam logic [127:0] C_LINE_11 = {16{8'h11}};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int w, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [127:0] d);
        case (w)
            0: begin bus4.pmem_read = rd;  bus4.pmem_write = wr;  bus4.pmem_address = a;  bus4.pmem_wdata = d;  end
            1: begin bus2.pmem_read = rd;  bus2.pmem_write = wr;  bus2.pmem_address = a;  bus2.pmem_wdata = d;  end
            default: begin bus15.pmem_read = rd; bus15.pmem_write = wr; bus15.pmem_address = a; bus15.pmem_wdata = d; end
        endcase
    endtask

    function automatic logic get_resp(input int w);
        case (w)
            0:       return bus4.pmem_resp;
            1:       return bus2.pmem_resp;
            default: return bus15.pmem_resp;
        endcase
    endfunction

    function automatic logic [127:0] get_rdata(input int w);
        case (w)
            0:       return bus4.pmem_rdata;
            1:       return bus2.pmem_rdata;
            default: return bus15.pmem_rdata;
        endcase
    endfunction

    function automatic logic get_err(input int w);
        case (w)
            0:       return bus4.proto_err;
            1:       return bus2.proto_err;
            default: return bus15.proto_err;
        endcase
    endfunction

    task automatic clear_models();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) model[w][i] = '0;
            last_rd[w] = '0;
            exp_err[w] = 1'b0;
        end
    endtask

    // One complete transaction: request scrambled and dropped right after
    // acceptance, latency measured in edges from the accepting edge.
    task automatic run_op(input int w, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [127:0] d,
                          input int lat, input string tag);
        int           idx;
        int           lat_seen;
        logic [127:0] expv;
        idx = int'(a[7:4]);
        if (rd) begin
            sb_q.push_back(model[w][idx]);
            if (wr) exp_err[w] = 1'b1;
        end else begin
            model[w][idx] = d;
        end
        @(negedge clk);
        set_req(w, rd, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        set_req(w, 1'b0, 1'b0, a ^ 16'h0FF0, ~d);
        lat_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_resp(w)) begin
                lat_seen = i;
                break;
            end
        end
        check({tag, " latency"}, 128'(lat_seen), 128'(lat));
        if (rd) begin
            expv = sb_q.pop_front();
            last_rd[w] = expv;
        end
        check({tag, " rdata"}, get_rdata(w), last_rd[w]);
        check({tag, " proto_err"}, 128'(get_err(w)), 128'(exp_err[w]));
        @(negedge clk);
        check({tag, " resp width"}, 128'(get_resp(w)), 128'(0));
    endtask

    initial begin
        int           resp_seen;
        int           gap;
        logic [127:0] expv;
        logic [15:0]  b2b_addr [3];
        checks = 0;
        errors = 0;
        clear_models();
        for (int w = 0; w < 3; w++) set_req(w, 1'b0, 1'b0, 16'h0000, '0);

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset resp", 128'(bus4.pmem_resp), 128'(0));
        check("reset rdata", bus4.pmem_rdata, 128'(0));
        check("reset proto_err", 128'(bus4.proto_err), 128'(0));
        rst_n = 1'b1;

        // Write then read back through a different byte offset of the line.
        run_op(0, 1'b0, 1'b1, 16'h0040, C_LINE_A, 4, "wr 0040");
        run_op(0, 1'b1, 1'b0, 16'h004A, '0, 4, "rd 004A");

        // Aliasing above the index bits, and an untouched line.
        run_op(0, 1'b0, 1'b1, 16'h0010, C_LINE_AA, 4, "wr 0010");
        run_op(0, 1'b1, 1'b0, 16'h0110, '0, 4, "rd 0110 alias");
        run_op(0, 1'b1, 1'b0, 16'h0020, '0, 4, "rd 0020 blank");

        // Read+write together: read wins, storage untouched, flag sticks.
        run_op(0, 1'b1, 1'b1, 16'h0030, C_LINE_55, 4, "conflict 0030");
        run_op(0, 1'b1, 1'b0, 16'h0030, '0, 4, "rd 0030 after conflict");

        // Back-to-back reads with pmem_read held high throughout.
        b2b_addr[0] = 16'h0000;
        b2b_addr[1] = 16'h0010;
        b2b_addr[2] = 16'h0020;
        for (int n = 0; n < 3; n++) sb_q.push_back(model[0][int'(b2b_addr[n][7:4])]);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, b2b_addr[0], '0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("b2b resp one cycle", 128'(bus4.pmem_resp), 128'(0));
            gap = 0;
            for (int c = 2; c <= 40; c++) begin
                @(negedge clk);
                if (bus4.pmem_resp) begin
                    gap = c;
                    break;
                end
            end
            check("b2b spacing", 128'(gap), 128'(5));
            expv = sb_q.pop_front();
            last_rd[0] = expv;
            check("b2b rdata", bus4.pmem_rdata, expv);
            if (n < 2) set_req(0, 1'b1, 1'b0, b2b_addr[n+1], '0);
            else       set_req(0, 1'b0, 1'b0, 16'h0000, '0);
        end
        @(negedge clk);
        check("b2b tail resp", 128'(bus4.pmem_resp), 128'(0));

        // Reset dropped while a write is in BUSY aborts it.
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 16'h0050, C_LINE_11);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 16'h0000, '0);
        rst_n = 1'b0;
        #1;
        check("async reset proto_err", 128'(bus4.proto_err), 128'(0));
        check("async reset resp", 128'(bus4.pmem_resp), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clear_models();
        resp_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus4.pmem_resp) resp_seen++;
        end
        check("aborted op resp count", 128'(resp_seen), 128'(0));
        run_op(0, 1'b1, 1'b0, 16'h0050, '0, 4, "rd 0050 after abort");
        run_op(0, 1'b1, 1'b0, 16'h0010, '0, 4, "rd 0010 after reset");

        // Latency extremes.
        run_op(1, 1'b0, 1'b1, 16'h0040, C_LINE_A, 2, "L2 wr 0040");
        run_op(1, 1'b1, 1'b0, 16'h004A, '0, 2, "L2 rd 004A");
        run_op(2, 1'b0, 1'b1, 16'h0040, C_LINE_A, 15, "L15 wr 0040");
        run_op(2, 1'b1, 1'b0, 16'h004A, '0, 15, "L15 rd 004A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
